if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter PC_RESET, default 32'h0000_3000, the first fetch address after reset.
REQ-002 The block SHALL have parameter IM_AW, default 10, the instruction-memory word-address width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 The block SHALL have port stall  input  1  hazard-unit freeze of the PC and the IF/ID register.
REQ-006 The block SHALL have port redirect  input  1  branch/jump taken, resolved in the D stage.
REQ-007 The block SHALL have port redirect_pc  input  32  the branch/jump target.
REQ-008 The block SHALL have port imem_addr  output  IM_AW  word address to the combinational instruction ROM, equal to pc_f[IM_AW+1:2].
REQ-009 The block SHALL have port imem_data  input  32  the instruction word returned in the same cycle.
REQ-010 The block SHALL have port pc_f  output  32  the current fetch PC.
REQ-011 The block SHALL have ports ir_d, pc_d and pc8_d  output  32 each: the D-stage instruction, its PC, and its PC+8 (jal/jalr link value).
REQ-012 The block SHALL have port imm16_d  output  16  ir_d[15:0], feeding the immediate extender.
REQ-013 The block SHALL have port extop_d  output  2  extender mode: 0 = sign, 1 = zero, 2 = upper (<<16).

Function
REQ-014 The PC register SHALL update once per cycle when stall=0: it loads redirect_pc if redirect=1, otherwise pc_f+4 (32-bit wrap-around, no carry out).
REQ-015 The architecture has a branch delay slot, so redirect SHALL NOT flush the IF/ID register; the delay-slot instruction enters D normally.
REQ-016 When stall=0, the IF/ID register SHALL capture ir_d<=imem_data, pc_d<=pc_f and pc8_d<=pc_f+8 on the same edge as the PC update.
REQ-017 When stall=1, the PC and all IF/ID fields SHALL hold; stall=1 SHALL take priority over a simultaneous redirect=1, and the redirect SHALL be ignored that cycle (the hazard unit keeps it asserted).
REQ-018 Fetch-to-D latency SHALL be exactly one cycle; throughput SHALL be one instruction per cycle when stall=0.
REQ-019 extop_d SHALL be decoded combinationally from ir_d[31:26]: 0x0C, 0x0D or 0x0E gives 1; 0x0F gives 2; every other opcode gives 0; the value 3 SHALL never be driven.
REQ-020 A redirect_pc whose bits [1:0] are not 00 SHALL be loaded unchanged; alignment is checked downstream.

Reset
REQ-021 While reset=0 at a rising edge: pc_f<=PC_RESET, ir_d<=0 (nop), pc_d<=PC_RESET, pc8_d<=PC_RESET+8; stall and redirect SHALL be ignored.
REQ-022 Reset asserted mid-operation SHALL take effect at the next edge regardless of stall, and any pending redirect SHALL be discarded.
REQ-023 Immediately after reset, extop_d=0 and imm16_d=0.
REQ-024 The first edge with reset=1 and stall=0 SHALL fetch the word at PC_RESET into D.

Configuration
REQ-025 With macro IF_PERF_CNT_EN defined, the block SHALL add output ports fetch_cnt (32) and stall_cnt (32).
REQ-026 Under IF_PERF_CNT_EN, fetch_cnt SHALL increment on every edge with reset=1 and stall=0, and stall_cnt SHALL increment on every edge with reset=1 and stall=1.
REQ-027 Under IF_PERF_CNT_EN, both counters SHALL clear to 0 on reset and wrap silently at 2^32.
REQ-028 Without IF_PERF_CNT_EN, neither port nor counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench scenario, reset: hold reset=0 for 3 cycles, then release -> pc_f=0x3000 and ir_d=0; after 1 edge pc_f=0x3004 and ir_d=ROM[0].
REQ-030 Bench scenario, stall: assert stall=1 for 2 cycles at pc_f=0x3008 -> pc_f, ir_d and pc_d unchanged for both cycles; the next edge gives pc_f=0x300C.
REQ-031 Bench scenario, redirect: redirect=1 with redirect_pc=0x3100 while pc_f=0x3010 -> next edge pc_f=0x3100 and pc_d=0x3010 (delay slot kept), then pc_d=0x3100.
REQ-032 Bench scenario, stall with redirect: stall=1 and redirect=1 together -> PC holds; release stall with redirect still 1 -> pc_f=redirect_pc.
REQ-033 Bench scenario, extop decode: ir_d opcodes 0x08 / 0x0D / 0x0F / 0x23 -> extop_d=0 / 1 / 2 / 0; imm16_d equals ir_d[15:0] in every case.
REQ-034 Bench scenario, IF_PERF_CNT_EN: 10 run cycles with 3 of them stalled, then reset=0 -> fetch_cnt=7 and stall_cnt=3, then both read 0 after the reset edge.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction-fetch stage with IF/ID pipeline register.
//
// Holds the fetch PC, drives the word address to a combinational instruction
// ROM and captures the returned word plus its PC and PC+8 into the IF/ID
// register. The architecture has a branch delay slot, so a redirect only
// steers the PC and never flushes IF/ID. A stall freezes PC and IF/ID and
// overrides any redirect in the same cycle.
//
// Optional feature macro: IF_PERF_CNT_EN adds fetch/stall performance counters.
//
// Parameters
//   PC_RESET     first fetch address after reset
//   IM_AW        instruction-memory word-address width
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   stall        freeze PC and IF/ID
//   redirect     branch/jump taken (resolved in D)
//   redirect_pc  branch/jump target
//   imem_addr    word address to instruction ROM (pc_f[IM_AW+1:2])
//   imem_data    instruction word returned in the same cycle
//   pc_f         current fetch PC
//   ir_d         D-stage instruction
//   pc_d         D-stage PC
//   pc8_d        D-stage PC+8 (link value)
//   imm16_d      ir_d[15:0]
//   extop_d      extender mode: 0 sign, 1 zero, 2 upper
//   fetch_cnt    (IF_PERF_CNT_EN) edges out of reset with stall=0
//   stall_cnt    (IF_PERF_CNT_EN) edges out of reset with stall=1
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      pc_f,
    output logic [31:0]      ir_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d,
    output logic [15:0]      imm16_d,
    output logic [1:0]       extop_d
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;

    localparam logic [1:0] EXT_SIGN  = 2'd0;
    localparam logic [1:0] EXT_ZERO  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    logic [XLEN-1:0] pc_next;

    // Next PC: redirect target (loaded unaligned as-is) or sequential +4.
    always_comb begin
        pc_next = pc_f + XLEN'(4);
        if (redirect) begin
            pc_next = redirect_pc;
        end
    end

    // PC and IF/ID register; stall freezes both and masks redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f  <= PC_RESET;
            ir_d  <= '0;
            pc_d  <= PC_RESET;
            pc8_d <= PC_RESET + XLEN'(8);
        end else if (!stall) begin
            pc_f  <= pc_next;
            ir_d  <= imem_data;
            pc_d  <= pc_f;
            pc8_d <= pc_f + XLEN'(8);
        end
    end

    assign imem_addr = pc_f[IM_AW+1:2];
    assign imm16_d   = ir_d[15:0];

    // Extender mode from the D-stage opcode; logical immediates zero-extend.
    always_comb begin
        extop_d = EXT_SIGN;
        case (ir_d[31:26])
            OP_ANDI, OP_ORI, OP_XORI: extop_d = EXT_ZERO;
            OP_LUI:                   extop_d = EXT_UPPER;
            default:                  extop_d = EXT_SIGN;
        endcase
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters, wrapping silently at 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + XLEN'(1);
        end else begin
            fetch_cnt <= fetch_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : directed, table-driven bench for if_stage.
// A local ROM model answers imem_addr combinationally; each table row gives
// the inputs for one clock edge and the hand-computed state after it.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_f;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic [15:0] imm16_d;
    logic [1:0]  extop_d;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] rom [0:1023];
    logic [5:0]  ops [0:7];

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    if_stage #(.PC_RESET(32'h0000_3000), .IM_AW(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc_f        (pc_f),
        .ir_d        (ir_d),
        .pc_d        (pc_d),
        .pc8_d       (pc8_d),
        .imm16_d     (imm16_d),
        .extop_d     (extop_d)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] exp_pc_f;
        logic [31:0] exp_pc_d;
        logic [31:0] exp_pc8_d;
        logic [1:0]  exp_extop;
    } vec_t;

    vec_t vecs [0:15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic edge_step(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // Full D-stage check; ir_d expected is the ROM word at the expected pc_d.
    task automatic check_state(input string tag, input logic [31:0] epf, input logic [31:0] epd,
                               input logic [31:0] ep8, input logic [1:0] eext);
        logic [31:0] eir;
        eir = rom[epd[11:2]];
        check({tag, ".pc_f"},      pc_f, epf);
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(epf[11:2]));
        check({tag, ".pc_d"},      pc_d, epd);
        check({tag, ".pc8_d"},     pc8_d, ep8);
        check({tag, ".ir_d"},      ir_d, eir);
        check({tag, ".imm16_d"},   32'(imm16_d), 32'(eir[15:0]));
        check({tag, ".extop_d"},   32'(extop_d), 32'(eext));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc_f"},    pc_f, 32'h0000_3000);
        check({tag, ".ir_d"},    ir_d, 32'h0);
        check({tag, ".pc_d"},    pc_d, 32'h0000_3000);
        check({tag, ".pc8_d"},   pc8_d, 32'h0000_3008);
        check({tag, ".imm16_d"}, 32'(imm16_d), 32'h0);
        check({tag, ".extop_d"}, 32'(extop_d), 32'h0);
    endtask

    initial begin
        // Opcode pattern repeats every 8 words; word 0 is at 0x3000.
        ops = '{6'h08, 6'h0D, 6'h0F, 6'h23, 6'h0C, 6'h0E, 6'h00, 6'h3F};
        for (int i = 0; i < 1024; i++) begin
            rom[i] = {ops[i % 8], 10'(i), 16'(16'(i) * 16'h0101 ^ 16'hA5C3)};
        end

        //          stall redir rpc            pc_f           pc_d           pc8_d          extop
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0000_3004, 32'h0000_3000, 32'h0000_3008, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0000_3008, 32'h0000_3004, 32'h0000_300C, 2'd1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h0000_3008, 32'h0000_3004, 32'h0000_300C, 2'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h0000_3008, 32'h0000_3004, 32'h0000_300C, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0000_300C, 32'h0000_3008, 32'h0000_3010, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0000_3010, 32'h0000_300C, 32'h0000_3014, 2'd0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_3100, 32'h0000_3100, 32'h0000_3010, 32'h0000_3018, 2'd1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h0000_3104, 32'h0000_3100, 32'h0000_3108, 2'd0};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_3200, 32'h0000_3104, 32'h0000_3100, 32'h0000_3108, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_3200, 32'h0000_3200, 32'h0000_3104, 32'h0000_310C, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0000_3204, 32'h0000_3200, 32'h0000_3208, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_3302, 32'h0000_3302, 32'h0000_3204, 32'h0000_320C, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h0000_3306, 32'h0000_3302, 32'h0000_330A, 2'd0};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3306, 32'h0000_330E, 2'd1};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004, 2'd0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h0000_0004, 32'h0000_0000, 32'h0000_0008, 2'd0};

        // Reset held 3 edges with stall/redirect asserted; both must be ignored.
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) edge_step(1'b1, 1'b1, 32'h0000_5000);
        check_reset_state("reset");

        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            edge_step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            check_state($sformatf("vec%0d", i), vecs[i].exp_pc_f, vecs[i].exp_pc_d,
                        vecs[i].exp_pc8_d, vecs[i].exp_extop);
        end

        // Mid-run reset under stall with a pending redirect: reset wins, redirect dropped.
        reset = 1'b0;
        edge_step(1'b1, 1'b1, 32'h0000_4000);
        check_reset_state("midreset");
        reset = 1'b1;
        edge_step(1'b0, 1'b0, 32'h0);
        check_state("postreset", 32'h0000_3004, 32'h0000_3000, 32'h0000_3008, 2'd0);

`ifdef IF_PERF_CNT_EN
        reset = 1'b0;
        edge_step(1'b0, 1'b0, 32'h0);
        check("perf.fetch_clr0", fetch_cnt, 32'd0);
        check("perf.stall_clr0", stall_cnt, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edge_step((i == 2) || (i == 5) || (i == 6), 1'b0, 32'h0);
        end
        check("perf.fetch_cnt", fetch_cnt, 32'd7);
        check("perf.stall_cnt", stall_cnt, 32'd3);
        reset = 1'b0;
        edge_step(1'b1, 1'b0, 32'h0);
        check("perf.fetch_clr", fetch_cnt, 32'd0);
        check("perf.stall_clr", stall_cnt, 32'd0);
        reset = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
